// File: rtl/spi_xfer_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : spi_xfer_sequencer_if
//  Purpose  : Bundles the bus-side TX/RX valid/ready streams, the SPI master
//             handshake and the status/error signals of spi_xfer_sequencer.
//  Modports : slave  - the sequencer itself (drives tx_ready, rx_*, spi_start,
//                      spi_wdata, busy, timeout_err, levels)
//             master - the surrounding environment (producer, consumer and
//                      SPI master core)
//  Params   : BIT_WIDTH / TX_DEPTH / RX_DEPTH must match the values given to
//             the sequencer instance that uses this interface.
//  Revision : 1.0 - initial release
// ============================================================================
interface spi_xfer_sequencer_if #(
   parameter int BIT_WIDTH = 16,
   parameter int TX_DEPTH  = 8,
   parameter int RX_DEPTH  = 8
);
   // bus-side TX stream
   logic [BIT_WIDTH-1:0]      tx_data;
   logic                      tx_valid;
   logic                      tx_ready;
   // bus-side RX stream
   logic [BIT_WIDTH-1:0]      rx_data;
   logic                      rx_valid;
   logic                      rx_ready;
   // SPI master handshake
   logic                      spi_start;
   logic [BIT_WIDTH-1:0]      spi_wdata;
   logic                      spi_done;
   logic [BIT_WIDTH-1:0]      spi_rdata;
   // status / error
   logic                      busy;
   logic                      timeout_err;
   logic                      err_clr;
   logic [$clog2(TX_DEPTH):0] tx_level;
   logic [$clog2(RX_DEPTH):0] rx_level;

   modport slave (
      input  tx_data, tx_valid, rx_ready, spi_done, spi_rdata, err_clr,
      output tx_ready, rx_data, rx_valid, spi_start, spi_wdata,
             busy, timeout_err, tx_level, rx_level
   );

   modport master (
      output tx_data, tx_valid, rx_ready, spi_done, spi_rdata, err_clr,
      input  tx_ready, rx_data, rx_valid, spi_start, spi_wdata,
             busy, timeout_err, tx_level, rx_level
   );
endinterface
`default_nettype wire

// File: rtl/spi_xfer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : spi_xfer_sequencer
//  Purpose  : Buffers outgoing words in a TX FIFO, launches one SPI transfer
//             per word (start pulse held 2 cycles, wdata held stable), waits
//             for the master's done pulse and stores the received word in an
//             RX FIFO. A watchdog aborts transfers that never complete.
//  Ports    : clk   - clock
//             rst_n - asynchronous active-low reset
//             bus   - spi_xfer_sequencer_if.slave (TX/RX streams, SPI
//                     handshake, busy, timeout_err/err_clr, FIFO levels)
//  Revision : 1.0 - initial release
// ============================================================================
module spi_xfer_sequencer #(
   parameter int BIT_WIDTH  = 16,
   parameter int TX_DEPTH   = 8,
   parameter int RX_DEPTH   = 8,
   parameter int TIMEOUT    = 1024,
   parameter int GAP_CYCLES = 2
) (
   input wire                   clk,
   input wire                   rst_n,
   spi_xfer_sequencer_if.slave  bus
);

   localparam int c_TX_AW  = $clog2(TX_DEPTH);
   localparam int c_RX_AW  = $clog2(RX_DEPTH);
   localparam int c_TX_LW  = c_TX_AW + 1;
   localparam int c_RX_LW  = c_RX_AW + 1;
   localparam int c_WD_W   = $clog2(TIMEOUT);
   localparam int c_GAP_W  = $clog2(GAP_CYCLES + 1);

   localparam logic [c_TX_AW-1:0] c_TX_PTR_ONE = c_TX_AW'(1);
   localparam logic [c_RX_AW-1:0] c_RX_PTR_ONE = c_RX_AW'(1);
   localparam logic [c_TX_LW-1:0] c_TX_LVL_ONE = c_TX_LW'(1);
   localparam logic [c_RX_LW-1:0] c_RX_LVL_ONE = c_RX_LW'(1);
   localparam logic [c_TX_LW-1:0] c_TX_FULL    = c_TX_LW'(TX_DEPTH);
   localparam logic [c_RX_LW-1:0] c_RX_FULL    = c_RX_LW'(RX_DEPTH);
   localparam logic [c_WD_W-1:0]  c_WD_ONE     = c_WD_W'(1);
   localparam logic [c_WD_W-1:0]  c_WD_LAST    = c_WD_W'(TIMEOUT - 1);
   localparam logic [c_GAP_W-1:0] c_GAP_ONE    = c_GAP_W'(1);
   localparam logic [c_GAP_W-1:0] c_GAP_LAST   = c_GAP_W'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_START = 3'd2,
      S_WAIT  = 3'd3,
      S_GAP   = 3'd4
   } state_t;

   state_t               r_state;
   logic                 r_spi_start;
   logic [BIT_WIDTH-1:0] r_spi_wdata;
   logic                 r_timeout_err;
   logic [1:0]           r_start_cnt;
   logic [c_WD_W-1:0]    r_wd_cnt;
   logic [c_GAP_W-1:0]   r_gap_cnt;

   // ------------------------------------------------------------------ TX FIFO
   logic [BIT_WIDTH-1:0] r_tx_mem [TX_DEPTH];
   logic [c_TX_AW-1:0]   r_tx_wr_ptr;
   logic [c_TX_AW-1:0]   r_tx_rd_ptr;
   logic [c_TX_LW-1:0]   r_tx_count;
   logic                 w_tx_ready;
   logic                 w_tx_push;
   logic                 w_tx_pop;

   assign w_tx_ready = (r_tx_count != c_TX_FULL);
   assign w_tx_push  = bus.tx_valid && w_tx_ready;
   // LOAD is only entered with a non-empty TX FIFO, so the pop is always legal.
   assign w_tx_pop   = (r_state == S_LOAD);

   always_ff @(posedge clk) begin
      if (w_tx_push) begin
         r_tx_mem[r_tx_wr_ptr] <= bus.tx_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tx_wr_ptr <= '0;
         r_tx_rd_ptr <= '0;
         r_tx_count  <= '0;
      end else begin
         if (w_tx_push) r_tx_wr_ptr <= r_tx_wr_ptr + c_TX_PTR_ONE;
         if (w_tx_pop)  r_tx_rd_ptr <= r_tx_rd_ptr + c_TX_PTR_ONE;
         case ({w_tx_push, w_tx_pop})
            2'b10:   r_tx_count <= r_tx_count + c_TX_LVL_ONE;
            2'b01:   r_tx_count <= r_tx_count - c_TX_LVL_ONE;
            default: r_tx_count <= r_tx_count;
         endcase
      end
   end

   // ------------------------------------------------------------------ RX FIFO
   logic [BIT_WIDTH-1:0] r_rx_mem [RX_DEPTH];
   logic [c_RX_AW-1:0]   r_rx_wr_ptr;
   logic [c_RX_AW-1:0]   r_rx_rd_ptr;
   logic [c_RX_LW-1:0]   r_rx_count;
   logic                 w_rx_valid;
   logic                 w_rx_push;
   logic                 w_rx_pop;

   assign w_rx_valid = (r_rx_count != '0);
   // No full check needed: a slot was reserved in IDLE before launching.
   assign w_rx_push  = (r_state == S_WAIT) && bus.spi_done;
   assign w_rx_pop   = w_rx_valid && bus.rx_ready;

   always_ff @(posedge clk) begin
      if (w_rx_push) begin
         r_rx_mem[r_rx_wr_ptr] <= bus.spi_rdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_wr_ptr <= '0;
         r_rx_rd_ptr <= '0;
         r_rx_count  <= '0;
      end else begin
         if (w_rx_push) r_rx_wr_ptr <= r_rx_wr_ptr + c_RX_PTR_ONE;
         if (w_rx_pop)  r_rx_rd_ptr <= r_rx_rd_ptr + c_RX_PTR_ONE;
         case ({w_rx_push, w_rx_pop})
            2'b10:   r_rx_count <= r_rx_count + c_RX_LVL_ONE;
            2'b01:   r_rx_count <= r_rx_count - c_RX_LVL_ONE;
            default: r_rx_count <= r_rx_count;
         endcase
      end
   end

   // ---------------------------------------------------------------------- FSM
   logic w_wd_expire;

   // done in the final watchdog cycle still counts as a completed transfer
   assign w_wd_expire = (r_state == S_WAIT) && !bus.spi_done && (r_wd_cnt == c_WD_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_spi_start   <= 1'b0;
         r_spi_wdata   <= '0;
         r_timeout_err <= 1'b0;
         r_start_cnt   <= '0;
         r_wd_cnt      <= '0;
         r_gap_cnt     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if ((r_tx_count != '0) && (r_rx_count < c_RX_FULL)) begin
                  r_state <= S_LOAD;
               end
            end
            S_LOAD: begin
               r_spi_wdata <= r_tx_mem[r_tx_rd_ptr];
               r_start_cnt <= '0;
               r_state     <= S_START;
            end
            // First START cycle leaves spi_start low so wdata has a full cycle
            // of setup; the next two cycles drive spi_start high.
            S_START: begin
               if (r_start_cnt == 2'd2) begin
                  r_spi_start <= 1'b0;
                  r_wd_cnt    <= '0;
                  r_state     <= S_WAIT;
               end else begin
                  r_spi_start <= 1'b1;
                  r_start_cnt <= r_start_cnt + 2'd1;
               end
            end
            S_WAIT: begin
               if (bus.spi_done || w_wd_expire) begin
                  r_gap_cnt <= '0;
                  r_state   <= S_GAP;
               end else begin
                  r_wd_cnt <= r_wd_cnt + c_WD_ONE;
               end
            end
            S_GAP: begin
               if (r_gap_cnt == c_GAP_LAST) begin
                  r_state <= S_IDLE;
               end else begin
                  r_gap_cnt <= r_gap_cnt + c_GAP_ONE;
               end
            end
            default: begin
               r_spi_start <= 1'b0;
               r_state     <= S_IDLE;
            end
         endcase

         // setting wins over a simultaneous clear request
         if (w_wd_expire) begin
            r_timeout_err <= 1'b1;
         end else if (bus.err_clr) begin
            r_timeout_err <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------ outputs
   assign bus.tx_ready    = w_tx_ready;
   assign bus.tx_level    = r_tx_count;
   assign bus.rx_valid    = w_rx_valid;
   assign bus.rx_data     = w_rx_valid ? r_rx_mem[r_rx_rd_ptr] : '0;
   assign bus.rx_level    = r_rx_count;
   assign bus.spi_start   = r_spi_start;
   assign bus.spi_wdata   = r_spi_wdata;
   assign bus.busy        = (r_state != S_IDLE);
   assign bus.timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_xfer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_xfer_sequencer
//  Purpose  : Directed self-checking bench for spi_xfer_sequencer with a
//             loopback SPI master model (rdata = wdata, done LAT cycles after
//             the start rising edge), a start-pulse shape monitor and an RX
//             order scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_xfer_sequencer;

   localparam int BW   = 16;
   localparam int TXD  = 8;
   localparam int RXD  = 8;
   localparam int TO   = 16;
   localparam int GAP  = 2;
   localparam int LAT  = 5;
   localparam int WMAX = 500;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   spi_xfer_sequencer_if #(.BIT_WIDTH(BW), .TX_DEPTH(TXD), .RX_DEPTH(RXD)) bus ();

   spi_xfer_sequencer #(
      .BIT_WIDTH (BW),
      .TX_DEPTH  (TXD),
      .RX_DEPTH  (RXD),
      .TIMEOUT   (TO),
      .GAP_CYCLES(GAP)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // ---------------------------------------------------------- master model
   bit       m_en       = 1'b1;
   int       stray_req  = 0;
   int       stray_seen = 0;
   int       m_cnt      = 0;
   logic     m_prev     = 1'b0;

   initial begin
      bus.spi_done  = 1'b0;
      bus.spi_rdata = '0;
      forever begin
         @(negedge clk);
         bus.spi_done = 1'b0;
         if (!rst_n) begin
            m_cnt  = 0;
            m_prev = 1'b0;
         end else begin
            if (m_cnt != 0) begin
               m_cnt--;
               if (m_cnt == 0 && m_en) begin
                  bus.spi_done  = 1'b1;
                  bus.spi_rdata = bus.spi_wdata;
               end
            end
            if (stray_seen != stray_req) begin
               stray_seen    = stray_req;
               bus.spi_done  = 1'b1;
               bus.spi_rdata = 16'hDEAD;
            end
            if (bus.spi_start && !m_prev && m_en) m_cnt = LAT;
            m_prev = bus.spi_start;
         end
      end
   end

   // ------------------------------------------------------ start pulse shape
   int   rises  = 0;
   int   hi_run = 0;
   int   lo_run = 100;
   logic s_prev = 1'b0;

   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (bus.spi_start) begin
            if (!s_prev) begin
               rises++;
               chk("start_low_gap", {31'd0, (lo_run >= GAP)}, 32'd1);
               hi_run = 0;
            end
            hi_run++;
         end else begin
            if (s_prev) begin
               chk("start_high_len", hi_run, 32'd2);
               lo_run = 0;
            end
            lo_run++;
         end
         s_prev = bus.spi_start;
      end
   end

   // --------------------------------------------------------- RX scoreboard
   logic [BW-1:0] exp_q[$];

   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (rst_n && bus.rx_valid && bus.rx_ready) begin
            if (exp_q.size() == 0) chk("rx_unexpected_word", {31'd0, bus.rx_valid}, 32'd0);
            else                   chk("rx_order", bus.rx_data, exp_q.pop_front());
         end
      end
   end

   // ---------------------------------------------------------------- helpers
   task automatic push_word(input logic [BW-1:0] w);
      int n = 0;
      exp_q.push_back(w);
      bus.tx_data  = w;
      bus.tx_valid = 1'b1;
      while (!bus.tx_ready && n < WMAX) begin
         tick();
         n++;
      end
      if (n == WMAX) chk("tx_ready_wait", {31'd0, bus.tx_ready}, 32'd1);
      tick();
      bus.tx_valid = 1'b0;
   endtask

   task automatic wait_drained(input string tag);
      int n = 0;
      while (!(bus.rx_level == 0 && bus.tx_level == 0 && !bus.busy) && n < WMAX) begin
         tick();
         n++;
      end
      chk(tag, {31'd0, (n < WMAX)}, 32'd1);
   endtask

   task automatic wait_rx_level(input int lvl, input string tag);
      int n = 0;
      while (bus.rx_level != lvl && n < WMAX) begin
         tick();
         n++;
      end
      chk(tag, bus.rx_level, lvl);
   endtask

   task automatic chk_reset_vals(input string p);
      chk({p, "_spi_start"},   bus.spi_start,   32'd0);
      chk({p, "_spi_wdata"},   bus.spi_wdata,   32'd0);
      chk({p, "_tx_ready"},    bus.tx_ready,    32'd1);
      chk({p, "_tx_level"},    bus.tx_level,    32'd0);
      chk({p, "_rx_valid"},    bus.rx_valid,    32'd0);
      chk({p, "_rx_data"},     bus.rx_data,     32'd0);
      chk({p, "_rx_level"},    bus.rx_level,    32'd0);
      chk({p, "_busy"},        bus.busy,        32'd0);
      chk({p, "_timeout_err"}, bus.timeout_err, 32'd0);
   endtask

   // -------------------------------------------------------------- watchdog
   initial begin
      #500000;
      $display("FAIL global_time_limit: simulation did not finish");
      $fatal(1, "bench time limit exceeded");
   end

   // ------------------------------------------------------------ stimulus
   int r0;

   initial begin
      bus.tx_data  = '0;
      bus.tx_valid = 1'b0;
      bus.rx_ready = 1'b0;
      bus.err_clr  = 1'b0;
      rst_n        = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk_reset_vals("reset");
      rst_n = 1'b1;
      tick();

      // ---- single word; edge N is the push edge
      r0 = rises;
      push_word(16'hA5C3);                              // after N
      chk("single_tx_level_N", bus.tx_level, 32'd1);
      chk("single_busy_N", bus.busy, 32'd0);
      tick();                                            // N+1 LOAD
      chk("single_busy_load", bus.busy, 32'd1);
      tick();                                            // N+2
      chk("single_tx_level_pop", bus.tx_level, 32'd0);
      chk("single_wdata", bus.spi_wdata, 32'hA5C3);
      chk("single_start_N2", bus.spi_start, 32'd0);
      tick();                                            // N+3
      chk("single_start_N3", bus.spi_start, 32'd1);
      tick();                                            // N+4
      chk("single_start_N4", bus.spi_start, 32'd1);
      tick();                                            // N+5 WAIT
      chk("single_start_N5", bus.spi_start, 32'd0);
      repeat (3) tick();                                 // N+8, done high now
      chk("single_rx_valid_before", bus.rx_valid, 32'd0);
      tick();                                            // N+9
      chk("single_rx_valid", bus.rx_valid, 32'd1);
      chk("single_rx_data", bus.rx_data, 32'hA5C3);
      chk("single_rx_level", bus.rx_level, 32'd1);
      chk("single_busy_gap", bus.busy, 32'd1);
      tick();                                            // N+10
      chk("single_busy_gap2", bus.busy, 32'd1);
      tick();                                            // N+11
      chk("single_busy_idle", bus.busy, 32'd0);
      chk("single_rises", rises - r0, 32'd1);
      bus.rx_ready = 1'b1;
      tick();
      bus.rx_ready = 1'b0;
      chk("single_rx_level_pop", bus.rx_level, 32'd0);
      chk("single_rx_valid_pop", bus.rx_valid, 32'd0);
      chk("single_rx_data_empty", bus.rx_data, 32'd0);

      // ---- burst of 8 with consumer always ready
      r0 = rises;
      bus.rx_ready = 1'b1;
      for (int i = 1; i <= 8; i++) push_word(BW'(i));
      wait_drained("burst_drained");
      chk("burst_rises", rises - r0, 32'd8);
      chk("burst_all_received", exp_q.size(), 32'd0);
      bus.rx_ready = 1'b0;

      // ---- RX backpressure: 10 words, only 8 may launch
      r0 = rises;
      for (int i = 0; i < 10; i++) push_word(16'h0100 + BW'(i));
      wait_rx_level(8, "bp_rx_full");
      repeat (GAP + 3) tick();
      chk("bp_busy_idle", bus.busy, 32'd0);
      chk("bp_tx_level", bus.tx_level, 32'd2);
      chk("bp_rx_level", bus.rx_level, 32'd8);
      chk("bp_rises", rises - r0, 32'd8);
      repeat (30) tick();
      chk("bp_rises_stalled", rises - r0, 32'd8);
      chk("bp_tx_level_stalled", bus.tx_level, 32'd2);
      bus.rx_ready = 1'b1;
      wait_drained("bp_drained");
      chk("bp_rises_final", rises - r0, 32'd10);
      chk("bp_all_received", exp_q.size(), 32'd0);
      bus.rx_ready = 1'b0;

      // ---- concurrency: TX push during LOAD, RX pop during RX push
      push_word(16'h0C0C);
      wait_rx_level(1, "conc_pre_rx");
      repeat (GAP + 2) tick();
      chk("conc_pre_idle", bus.busy, 32'd0);
      push_word(16'h0A0A);                              // after N
      chk("conc_tx_level_N", bus.tx_level, 32'd1);
      tick();                                            // N+1 LOAD
      chk("conc_busy_load", bus.busy, 32'd1);
      push_word(16'h0B0B);                              // push at N+2 with pop
      chk("conc_tx_level_same", bus.tx_level, 32'd1);
      chk("conc_wdata", bus.spi_wdata, 32'h0A0A);
      repeat (6) tick();                                 // N+8, done high now
      chk("conc_rx_level_pre", bus.rx_level, 32'd1);
      bus.rx_ready = 1'b1;                              // pop at N+9 with push
      tick();
      bus.rx_ready = 1'b0;
      chk("conc_rx_level_same", bus.rx_level, 32'd1);
      chk("conc_rx_head", bus.rx_data, 32'h0A0A);
      bus.rx_ready = 1'b1;
      wait_drained("conc_drained");
      chk("conc_all_received", exp_q.size(), 32'd0);
      bus.rx_ready = 1'b0;

      // ---- watchdog: master never answers
      m_en = 1'b0;
      r0   = rises;
      push_word(16'h1111);                              // after N
      push_word(16'h2222);                              // after N+1
      exp_q.delete();
      repeat (19) tick();                                // N+20
      chk("to_not_yet", bus.timeout_err, 32'd0);
      tick();                                            // N+21
      chk("to_set", bus.timeout_err, 32'd1);
      chk("to_rx_empty", bus.rx_valid, 32'd0);
      chk("to_busy_gap", bus.busy, 32'd1);
      repeat (4) tick();                                 // N+25
      chk("to_next_tx_level", bus.tx_level, 32'd0);
      chk("to_next_wdata", bus.spi_wdata, 32'h2222);
      chk("to_sticky", bus.timeout_err, 32'd1);
      tick();                                            // N+26
      bus.err_clr = 1'b1;
      tick();                                            // N+27
      bus.err_clr = 1'b0;
      chk("to_cleared", bus.timeout_err, 32'd0);
      repeat (16) tick();                                // N+43
      bus.err_clr = 1'b1;
      tick();                                            // N+44, set beats clear
      chk("to_set_priority", bus.timeout_err, 32'd1);
      tick();                                            // N+45
      bus.err_clr = 1'b0;
      chk("to_clear_after", bus.timeout_err, 32'd0);
      chk("to_rx_level", bus.rx_level, 32'd0);
      wait_drained("to_drained");
      chk("to_rises", rises - r0, 32'd2);

      // ---- reset mid-WAIT with words queued
      push_word(16'h3001);                              // after N
      push_word(16'h3002);
      push_word(16'h3003);                              // after N+2
      repeat (4) tick();                                 // N+6, in WAIT
      chk("rst_busy_before", bus.busy, 32'd1);
      chk("rst_tx_level_before", bus.tx_level, 32'd2);
      rst_n = 1'b0;
      #1;
      chk_reset_vals("midrst");
      tick();
      rst_n = 1'b1;
      exp_q.delete();
      m_en = 1'b1;
      stray_req++;
      repeat (4) tick();
      chk("stray_rx_level", bus.rx_level, 32'd0);
      chk("stray_rx_valid", bus.rx_valid, 32'd0);
      chk("stray_busy", bus.busy, 32'd0);
      chk("stray_tx_level", bus.tx_level, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/spi_xfer_sequencer.md
# spi_xfer_sequencer

Upstream command/data sequencer for the SPI master core. It buffers outgoing words in a TX FIFO and launches one SPI transfer per word: it drives the core's `start` rising edge, holds `wdata` stable, and waits for the `done` pulse. On `done` it captures the received word into an RX FIFO. It sits between the bus-side producer/consumer (valid/ready streams) and the SPI master, and includes a watchdog for transfers that never complete.

## Interface
- `BIT_WIDTH`, 16: SPI word width; must equal the master's BIT_WIDTH.
- `TX_DEPTH`, 8: TX FIFO depth, power of two, ≥2.
- `RX_DEPTH`, 8: RX FIFO depth, power of two, ≥2.
- `TIMEOUT`, 1024: max cycles in WAIT before abort, ≥4.
- `GAP_CYCLES`, 2: cycles `spi_start` stays low between transfers, ≥1.

- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `tx_data` in BIT_WIDTH: word to transmit.
- `tx_valid` in 1: `tx_data` valid.
- `tx_ready` out 1: TX FIFO not full.
- `rx_data` out BIT_WIDTH: RX FIFO head.
- `rx_valid` out 1: RX FIFO not empty.
- `rx_ready` in 1: consumer accepts `rx_data`.
- `spi_start` out 1: start request to the master (registered).
- `spi_wdata` out BIT_WIDTH: word to the master (registered).
- `spi_done` in 1: one-cycle completion pulse from the master.
- `spi_rdata` in BIT_WIDTH: received word; valid while `spi_done`=1.
- `busy` out 1: state ≠ IDLE.
- `timeout_err` out 1: sticky watchdog flag.
- `err_clr` in 1: clears `timeout_err`.
- `tx_level` out $clog2(TX_DEPTH)+1: TX occupancy.
- `rx_level` out $clog2(RX_DEPTH)+1: RX occupancy.

## Operation
- The FIFOs are synchronous, first-word-fall-through, with count-based full/empty.
- TX push occurs when `tx_valid && tx_ready`. RX pop occurs when `rx_valid && rx_ready`.
- The FSM has states IDLE, LOAD, START, WAIT, GAP.
  - IDLE → LOAD when TX is not empty and `rx_level < RX_DEPTH`. Reserving the RX slot before launch means the RX FIFO can never overflow.
  - LOAD: pop the TX head into `spi_wdata`. → START.
  - START: `spi_start`=1 for exactly 2 cycles, then → WAIT. The 2-cycle hold guarantees the master detects the rising edge.
  - WAIT: `spi_start`=0 and the watchdog counter increments each cycle.
    - On `spi_done`=1, push `spi_rdata` into RX and → GAP.
    - If the counter reaches TIMEOUT-1 without `spi_done`, set `timeout_err`, push nothing (the word is dropped) and → GAP.
  - GAP: hold for GAP_CYCLES cycles, then → IDLE.
- `spi_wdata` stays unchanged from LOAD until the next LOAD.
- `spi_done` is ignored in every state except WAIT.
- `timeout_err`:
  - set has priority over `err_clr` in the same cycle;
  - `err_clr` otherwise clears it on the next edge;
  - the flag does not stall the FSM.
- Simultaneous RX push (sequencer) and pop (consumer): `rx_level` is unchanged.
- Simultaneous TX push and LOAD pop: `tx_level` is unchanged.
- Reset values: all FIFO pointers and levels 0, state IDLE, `spi_start`=0, `spi_wdata`=0, `tx_ready`=1, `rx_valid`=0, `rx_data`=0, `busy`=0, `timeout_err`=0.
- Asserting reset mid-transfer aborts immediately and discards FIFO contents. `spi_start` falls asynchronously.

## Timing
- Word accepted at edge N (TX empty, RX has space, state IDLE):
  - `tx_level`=1 after N;
  - LOAD from N+1, with `spi_wdata` valid after N+2;
  - `spi_start`=1 during cycles N+3..N+4;
  - WAIT from N+5.
- `spi_done` high in cycle D:
  - `rx_valid`=1 and `rx_data`=`spi_rdata` after edge D+1;
  - GAP lasts GAP_CYCLES cycles;
  - the earliest next LOAD is D+1+GAP_CYCLES+1.
- Watchdog abort: `timeout_err` rises TIMEOUT cycles after WAIT entry.
- Steady-state throughput is one word per (transfer time + GAP_CYCLES + 4) cycles.

## Test plan
- Single word: push 0xA5C3 with the loopback master (MISO tied to MOSI), BIT_WIDTH=16 → `spi_start` high exactly 2 cycles; `rx_data`=0xA5C3, `rx_valid`=1, `tx_level`=0, `busy` returns to 0.
- Burst: push 0x0001..0x0008 back-to-back with `rx_ready`=1 → 8 `spi_start` rising edges, each separated by ≥GAP_CYCLES low cycles; RX outputs 0x0001..0x0008 in order, none lost.
- RX backpressure: `rx_ready`=0 and 10 words pushed → exactly 8 transfers, then FSM idles with `tx_level`=2 and `rx_level`=8; releasing `rx_ready` completes the remaining 2 transfers.
- Timeout: `spi_done` tied low, TIMEOUT=16 → `timeout_err` rises 16 cycles after WAIT entry and RX stays empty; the next word is launched; `err_clr` pulse → flag returns to 0.
- Reset mid-WAIT: assert `rst_n`=0 with 3 words queued → all outputs at reset values; a stray `spi_done` after release produces no RX push.
- Concurrency: push TX during LOAD and pop RX during the RX push → `tx_level` and `rx_level` each unchanged that cycle, with data order preserved.
